// File: rtl/smpc_peri_pkg.sv
// Shared types and constants for the SMPC peripheral responder.
// Holds the FSM state encoding, port-status bytes and pad bit map.
package smpc_peri_pkg;

  typedef enum logic [4:0] {
    IDLE    = 5'b00001,
    LATCH   = 5'b00010,
    GAP     = 5'b00100,
    SEND    = 5'b01000,
    WAITPOS = 5'b10000
  } state_t;

  localparam logic [7:0] PORT_DIRECT = 8'hF1;
  localparam logic [7:0] PORT_NONE   = 8'hF0;
  localparam logic [2:0] PAD_TAIL    = 3'b100;

  localparam int JOY_RIGHT = 15;
  localparam int JOY_LEFT  = 14;
  localparam int JOY_DOWN  = 13;
  localparam int JOY_UP    = 12;
  localparam int JOY_START = 11;
  localparam int JOY_A     = 10;
  localparam int JOY_C     = 9;
  localparam int JOY_B     = 8;
  localparam int JOY_R     = 7;
  localparam int JOY_X     = 6;
  localparam int JOY_Y     = 5;
  localparam int JOY_Z     = 4;
  localparam int JOY_L     = 3;

  // Byte idx of one port's report; buttons go out active-low.
  function automatic logic [7:0] port_byte(
    input logic        present,
    input logic [7:0]  pad_id,
    input logic [15:0] joy,
    input logic [1:0]  idx
  );
    logic [7:0] b;
    b = 8'h00;
    unique case (idx)
      2'd0: b = present ? PORT_DIRECT : PORT_NONE;
      2'd1: b = pad_id;
      2'd2: b = ~{joy[JOY_RIGHT], joy[JOY_LEFT],
                  joy[JOY_DOWN], joy[JOY_UP],
                  joy[JOY_START], joy[JOY_A],
                  joy[JOY_C], joy[JOY_B]};
      default: b = {~{joy[JOY_R], joy[JOY_X],
                      joy[JOY_Y], joy[JOY_Z],
                      joy[JOY_L]}, PAD_TAIL};
    endcase
    return b;
  endfunction

endpackage

// File: rtl/smpc_peri_byte_sel.sv
// Combinational byte map: pad snapshot + OREG position -> byte.
// Ports: joy1/joy2, pad1/pad2 snapshot in; pos in; data out.
module smpc_peri_byte_sel
  import smpc_peri_pkg::*;
#(
  parameter logic [7:0] PAD_ID = 8'h02
) (
  input  logic [15:0] joy1,
  input  logic [15:0] joy2,
  input  logic        pad1,
  input  logic        pad2,
  input  logic [4:0]  pos,
  output logic [7:0]  data
);

  logic [4:0] len1;
  logic [4:0] len2;
  logic [4:0] off;
  logic       unused_bits;

  assign unused_bits = ^{joy1[2:0], joy2[2:0]};

  always_comb begin
    len1 = pad1 ? 5'd4 : 5'd1;
    len2 = pad2 ? 5'd4 : 5'd1;
    // Wraps when pos < len1, but that branch wins first.
    off  = pos - len1;
    data = 8'h00;
    if (pos < len1) begin
      data = port_byte(pad1, PAD_ID, joy1, pos[1:0]);
    end else if (off < len2) begin
      data = port_byte(pad2, PAD_ID, joy2, off[1:0]);
    end
  end

endmodule

// File: rtl/smpc_peri_responder.sv
// SMPC peripheral-input responder: snapshots two pads per INTBACK
// and strobes one byte per OREG position.
// Ports: CLK, RST, CE; INPUT_ACT/POS in; INPUT_DATA/WE out;
// PAD1/2_PRESENT, JOY1/JOY2 button vectors in.
module smpc_peri_responder
  import smpc_peri_pkg::*;
#(
  parameter int         BYTE_GAP = 4,
  parameter int         LAST_POS = 30,
  parameter logic [7:0] PAD_ID   = 8'h02
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE,
  input  logic        INPUT_ACT,
  input  logic [4:0]  INPUT_POS,
  output logic [7:0]  INPUT_DATA,
  output logic        INPUT_WE,
  input  logic        PAD1_PRESENT,
  input  logic        PAD2_PRESENT,
  input  logic [15:0] JOY1,
  input  logic [15:0] JOY2
);

  state_t      state;
  state_t      state_n;
  logic        act_q;
  logic [7:0]  gap_q;
  logic [7:0]  gap_n;
  logic [4:0]  pos_q;
  logic [4:0]  pos_n;
  logic        snap_en;
  logic        we_n;
  logic [7:0]  data_n;
  logic [15:0] j1_q;
  logic [15:0] j2_q;
  logic        p1_q;
  logic        p2_q;
  logic [7:0]  sel;

  smpc_peri_byte_sel #(
    .PAD_ID(PAD_ID)
  ) u_sel (
    .joy1(j1_q),
    .joy2(j2_q),
    .pad1(p1_q),
    .pad2(p2_q),
    .pos (INPUT_POS),
    .data(sel)
  );

  always_comb begin
    state_n = state;
    gap_n   = gap_q;
    pos_n   = pos_q;
    snap_en = 1'b0;
    we_n    = 1'b0;
    data_n  = INPUT_DATA;
    if (state != IDLE && !INPUT_ACT) begin
      state_n = IDLE;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (INPUT_ACT && !act_q) state_n = LATCH;
        end
        (state == LATCH): begin
          snap_en = 1'b1;
          gap_n   = 8'(BYTE_GAP);
          state_n = GAP;
        end
        (state == GAP): begin
          gap_n = gap_q - 8'd1;
          if (gap_q <= 8'd1) state_n = SEND;
        end
        (state == SEND): begin
          we_n    = 1'b1;
          data_n  = sel;
          pos_n   = INPUT_POS;
          state_n = WAITPOS;
        end
        (state == WAITPOS): begin
          if (INPUT_POS != pos_q) begin
            if (pos_q == 5'(LAST_POS)) begin
              state_n = IDLE;
            end else begin
              gap_n   = 8'(BYTE_GAP);
              state_n = GAP;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // act_q resets high so an ACT already high at reset release
  // is not mistaken for a fresh request.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      act_q      <= 1'b1;
      gap_q      <= 8'd0;
      pos_q      <= 5'd0;
      INPUT_WE   <= 1'b0;
      INPUT_DATA <= 8'h00;
      j1_q       <= 16'h0000;
      j2_q       <= 16'h0000;
      p1_q       <= 1'b0;
      p2_q       <= 1'b0;
    end else if (CE) begin
      state      <= state_n;
      act_q      <= INPUT_ACT;
      gap_q      <= gap_n;
      pos_q      <= pos_n;
      INPUT_WE   <= we_n;
      INPUT_DATA <= data_n;
      if (snap_en) begin
        j1_q <= JOY1;
        j2_q <= JOY2;
        p1_q <= PAD1_PRESENT;
        p2_q <= PAD2_PRESENT;
      end
    end
  end

endmodule

// File: tb/tb_smpc_peri_responder.sv
// Bench for smpc_peri_responder: byte map vectors plus
// full, aborted and reset-interrupted transfers.
module tb_smpc_peri_responder;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CE;
  logic        INPUT_ACT;
  logic [4:0]  INPUT_POS;
  logic [7:0]  INPUT_DATA;
  logic        INPUT_WE;
  logic        PAD1_PRESENT;
  logic        PAD2_PRESENT;
  logic [15:0] JOY1;
  logic [15:0] JOY2;

  logic [15:0] sj1;
  logic [15:0] sj2;
  logic        sp1;
  logic        sp2;
  logic [4:0]  spos;
  logic [7:0]  sdata;

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] exp_q [32];

  always #5 CLK = ~CLK;

  smpc_peri_responder dut (
    .CLK         (CLK),
    .RST         (RST),
    .CE          (CE),
    .INPUT_ACT   (INPUT_ACT),
    .INPUT_POS   (INPUT_POS),
    .INPUT_DATA  (INPUT_DATA),
    .INPUT_WE    (INPUT_WE),
    .PAD1_PRESENT(PAD1_PRESENT),
    .PAD2_PRESENT(PAD2_PRESENT),
    .JOY1        (JOY1),
    .JOY2        (JOY2)
  );

  smpc_peri_byte_sel u_bs (
    .joy1(sj1),
    .joy2(sj2),
    .pad1(sp1),
    .pad2(sp2),
    .pos (spos),
    .data(sdata)
  );

  typedef struct {
    logic [15:0] j1;
    logic [15:0] j2;
    logic        p1;
    logic        p2;
    logic [4:0]  pos;
    logic [7:0]  exp;
  } vec_t;

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // One CE tick: CE high across one edge, low across the next.
  task automatic step();
    @(negedge CLK);
    CE = 1'b1;
    @(posedge CLK);
    #1;
    CE = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  // Head bytes MSB first; remaining positions are zero.
  task automatic set_exp(input logic [63:0] head, input int n);
    for (int i = 0; i < 32; i++) exp_q[i] = 8'h00;
    for (int i = 0; i < n; i++) exp_q[i] = head[63-8*i -: 8];
  endtask

  task automatic idle_ticks(input string nm, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (INPUT_WE) seen++;
    end
    chk(nm, seen, 0);
  endtask

  // Raise ACT and act as the SMPC until stop_after strobes.
  task automatic stream(input string nm, input int stop_after,
                        input bit joy_swap);
    int n;
    int last;
    n = 0;
    last = -100;
    INPUT_POS = 5'd0;
    INPUT_ACT = 1'b1;
    for (int t = 0; t < 400; t++) begin
      step();
      if (joy_swap && t == 1) JOY1 = 16'hFFFF;
      if (INPUT_WE) begin
        chk($sformatf("%s byte@%0d", nm, INPUT_POS),
            INPUT_DATA, exp_q[INPUT_POS]);
        if (n > 0 && t - last < 5)
          chk($sformatf("%s spacing@%0d", nm, INPUT_POS),
              t - last, 5);
        last = t;
        n++;
        INPUT_POS = INPUT_POS + 5'd1;
        if (n == stop_after) break;
      end
    end
    chk({nm, " strobes"}, n, stop_after);
  endtask

  vec_t vecs [20];

  initial begin
    vecs[0]  = '{16'h0000, 16'h0000, 1, 1, 5'd0,  8'hF1};
    vecs[1]  = '{16'h0000, 16'h0000, 1, 1, 5'd1,  8'h02};
    vecs[2]  = '{16'h0000, 16'h0000, 1, 1, 5'd3,  8'hFC};
    vecs[3]  = '{16'h0000, 16'h0000, 1, 1, 5'd4,  8'hF1};
    vecs[4]  = '{16'h0000, 16'h0000, 1, 1, 5'd7,  8'hFC};
    vecs[5]  = '{16'h0000, 16'h0000, 1, 1, 5'd8,  8'h00};
    vecs[6]  = '{16'h8008, 16'h0000, 1, 0, 5'd2,  8'h7F};
    vecs[7]  = '{16'h8008, 16'h0000, 1, 0, 5'd3,  8'hF4};
    vecs[8]  = '{16'h8008, 16'h0000, 1, 0, 5'd4,  8'hF0};
    vecs[9]  = '{16'h8008, 16'h0000, 1, 0, 5'd5,  8'h00};
    vecs[10] = '{16'h0000, 16'h0080, 0, 1, 5'd0,  8'hF0};
    vecs[11] = '{16'h0000, 16'h0080, 0, 1, 5'd1,  8'hF1};
    vecs[12] = '{16'h0000, 16'h0080, 0, 1, 5'd2,  8'h02};
    vecs[13] = '{16'h0000, 16'h0080, 0, 1, 5'd4,  8'h7C};
    vecs[14] = '{16'h0000, 16'h0080, 0, 1, 5'd5,  8'h00};
    vecs[15] = '{16'h0000, 16'h0000, 0, 0, 5'd1,  8'hF0};
    vecs[16] = '{16'h0000, 16'h0000, 0, 0, 5'd2,  8'h00};
    vecs[17] = '{16'h0000, 16'h0000, 0, 0, 5'd30, 8'h00};
    vecs[18] = '{16'h0000, 16'h0000, 0, 0, 5'd31, 8'h00};
    vecs[19] = '{16'h0000, 16'h4200, 1, 1, 5'd6,  8'hBD};

    for (int i = 0; i < 20; i++) begin
      sj1  = vecs[i].j1;
      sj2  = vecs[i].j2;
      sp1  = vecs[i].p1;
      sp2  = vecs[i].p2;
      spos = vecs[i].pos;
      #1;
      chk($sformatf("sel vec%0d", i), sdata, vecs[i].exp);
    end

    RST = 1'b1;
    CE = 1'b0;
    INPUT_ACT = 1'b0;
    INPUT_POS = 5'd0;
    PAD1_PRESENT = 1'b1;
    PAD2_PRESENT = 1'b1;
    JOY1 = 16'h0000;
    JOY2 = 16'h0000;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    chk("reset we", INPUT_WE, 0);
    chk("reset data", INPUT_DATA, 8'h00);
    idle_ticks("idle no act", 3);

    // Both pads, no buttons; then confirm IDLE after pos 30.
    set_exp(64'hF102FFFC_F102FFFC, 8);
    stream("both", 31, 1'b0);
    idle_ticks("after last", 60);
    INPUT_ACT = 1'b0;
    step();

    PAD2_PRESENT = 1'b0;
    JOY1 = 16'h8008;
    set_exp(64'hF1027FF4_F0000000, 5);
    stream("pad1only", 31, 1'b0);
    INPUT_ACT = 1'b0;
    step();

    PAD1_PRESENT = 1'b0;
    set_exp(64'hF0F00000_00000000, 2);
    stream("none", 31, 1'b0);
    idle_ticks("none idle", 20);
    INPUT_ACT = 1'b0;
    step();

    // Buttons change after LATCH; stream keeps the snapshot.
    PAD1_PRESENT = 1'b1;
    JOY1 = 16'h0000;
    set_exp(64'hF102FFFC_F0000000, 5);
    stream("snapshot", 31, 1'b1);
    INPUT_ACT = 1'b0;
    step();

    // Abort after three strobes, then a fresh snapshot.
    PAD2_PRESENT = 1'b1;
    JOY1 = 16'h0000;
    set_exp(64'hF102FFFC_F102FFFC, 8);
    stream("abort", 3, 1'b0);
    INPUT_ACT = 1'b0;
    step();
    chk("abort we", INPUT_WE, 0);
    idle_ticks("abort quiet", 100);
    JOY1 = 16'hFFFF;
    set_exp(64'hF1020004_F102FFFC, 8);
    stream("restart", 31, 1'b0);
    INPUT_ACT = 1'b0;
    step();

    // Reset mid-GAP with CE low; held ACT must not restart.
    JOY1 = 16'h0000;
    set_exp(64'hF102FFFC_F102FFFC, 8);
    stream("pre-rst", 2, 1'b0);
    step();
    step();
    step();
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    chk("rst we", INPUT_WE, 0);
    chk("rst data", INPUT_DATA, 8'h00);
    idle_ticks("rst held act", 60);
    INPUT_ACT = 1'b0;
    step();
    stream("post-rst", 31, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
